// File: rtl/t_bank_pkg.sv
// rtl/t_bank_pkg.sv - shared encodings and Gray helpers for the toggle-bank controller
package t_bank_pkg;

    localparam int GW = 32;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_RUN   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        MODE_BIN_UP  = 2'b00,
        MODE_BIN_DN  = 2'b01,
        MODE_GRAY_UP = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_LOAD = 2'b10
    } state_t;

    // Helpers work on GW bits; callers zero-extend narrower values.
    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/t_cell.sv
// rtl/t_cell.sv - single toggle flip-flop cell
module t_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/t_bank_ctrl.sv
// rtl/t_bank_ctrl.sv - sequencer driving a bank of toggle cells as counter / loadable register
module t_bank_ctrl
    import t_bank_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_mode,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             halt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             done
);

    state_t           state, state_next;
    mode_t            mode_r, mode_next;
    logic [WIDTH-1:0] limit_r, limit_next;
    logic [WIDTH-1:0] target_r, target_next;
    logic             done_next;

    logic [WIDTH-1:0] up_t, dn_t, gray_t, gray_nb;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t_vec[i]),
            .q     (q[i])
        );
    end

    // Ripple-style toggle enables: a bit flips when all lower bits are at the carry/borrow value.
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q[i-1];
            dn_t[i] = dn_t[i-1] & ~q[i-1];
        end
        // Truncate before re-encoding so the Gray maximum wraps to zero.
        gray_nb = WIDTH'(gray2bin(GW'(q)) + GW'(1));
        gray_t  = q ^ WIDTH'(bin2gray(GW'(gray_nb)));
    end

    always_comb begin
        t_vec = '0;
        case (state)
            ST_RUN: begin
                if (!halt) begin
                    case (mode_r)
                        MODE_BIN_UP:  t_vec = up_t;
                        MODE_BIN_DN:  t_vec = dn_t;
                        MODE_GRAY_UP: t_vec = gray_t;
                        default:      t_vec = '0;
                    endcase
                end
            end
            ST_LOAD: t_vec = q ^ target_r;
            default: t_vec = '0;
        endcase
    end

    always_comb begin
        state_next  = state;
        mode_next   = mode_r;
        limit_next  = limit_r;
        target_next = target_r;
        done_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RUN: begin
                            mode_next  = mode_t'(cmd_mode);
                            limit_next = cmd_data;
                            if (q == cmd_data) begin
                                done_next = 1'b1;
                            end else begin
                                state_next = ST_RUN;
                            end
                        end
                        OP_LOAD: begin
                            target_next = cmd_data;
                            state_next  = ST_LOAD;
                        end
                        OP_CLEAR: begin
                            target_next = '0;
                            state_next  = ST_LOAD;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_IDLE;
                end else if ((q ^ t_vec) == limit_r) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            ST_LOAD: begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_r   <= MODE_BIN_UP;
            limit_r  <= '0;
            target_r <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            mode_r   <= mode_next;
            limit_r  <= limit_next;
            target_r <= target_next;
            done     <= done_next;
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_t_bank_ctrl.sv
// tb/tb_t_bank_ctrl.sv - directed table-driven bench for t_bank_ctrl
module tb_t_bank_ctrl;
    import t_bank_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_data;
    logic       halt;
    logic [3:0] q;
    logic [3:0] t_vec;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    t_bank_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mode  (cmd_mode),
        .cmd_data  (cmd_data),
        .halt      (halt),
        .q         (q),
        .t_vec     (t_vec),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [1:0] mode;
        logic [3:0] data;
        logic [3:0] exp_q;
        int         exp_n;
    } vec_t;

    vec_t vecs[11];

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [1:0] op, input logic [1:0] mode, input logic [3:0] data);
        int guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk1("send_ready_timeout", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mode  = mode;
        cmd_data  = data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [1:0] mode, input logic [3:0] data,
                          output int n);
        n = 0;
        send(op, mode, data);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) n = -1;
    endtask

    logic [3:0] gray_seq[16];
    int         n;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_mode  = MODE_BIN_UP;
        cmd_data  = '0;
        halt      = 1'b0;

        vecs[0]  = '{OP_CLEAR, MODE_BIN_UP,  4'h0, 4'h0, 1};
        vecs[1]  = '{OP_LOAD,  MODE_BIN_UP,  4'h5, 4'h5, 1};
        vecs[2]  = '{OP_RUN,   MODE_BIN_UP,  4'h9, 4'h9, 4};
        vecs[3]  = '{OP_RUN,   MODE_BIN_DN,  4'h6, 4'h6, 3};
        vecs[4]  = '{OP_RUN,   MODE_GRAY_UP, 4'h4, 4'h4, 3};
        vecs[5]  = '{OP_RUN,   MODE_BIN_UP,  4'h4, 4'h4, 0};
        vecs[6]  = '{OP_LOAD,  MODE_BIN_UP,  4'hF, 4'hF, 1};
        vecs[7]  = '{OP_RUN,   MODE_BIN_UP,  4'h2, 4'h2, 3};
        vecs[8]  = '{OP_RUN,   MODE_BIN_DN,  4'hE, 4'hE, 4};
        vecs[9]  = '{OP_CLEAR, MODE_BIN_UP,  4'h7, 4'h0, 1};
        vecs[10] = '{OP_RUN,   MODE_BIN_DN,  4'h0, 4'h0, 0};

        gray_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        #1;
        chk4("reset_q", q, 4'h0);
        chk4("reset_t_vec", t_vec, 4'h0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("reset_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 11; i++) begin
            do_cmd(vecs[i].op, vecs[i].mode, vecs[i].data, n);
            chki($sformatf("vec%0d_latency", i), n, vecs[i].exp_n);
            chk4($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            chk1($sformatf("vec%0d_ready", i), cmd_ready, 1'b1);
            @(negedge clk);
            chk1($sformatf("vec%0d_done_once", i), done, 1'b0);
        end

        // BIN_UP wrap E,F,0,1
        do_cmd(OP_LOAD, MODE_BIN_UP, 4'hE, n);
        @(negedge clk);
        send(OP_RUN, MODE_BIN_UP, 4'h1);
        chk4("wrap_q_e", q, 4'hE);
        chk4("wrap_t_e", t_vec, 4'h1);
        @(negedge clk);
        chk4("wrap_q_f", q, 4'hF);
        chk4("wrap_t_f", t_vec, 4'hF);
        @(negedge clk);
        chk4("wrap_q_0", q, 4'h0);
        chk1("wrap_no_done", done, 1'b0);
        @(negedge clk);
        chk4("wrap_q_1", q, 4'h1);
        chk1("wrap_done", done, 1'b1);
        chk1("wrap_busy", busy, 1'b0);
        @(negedge clk);
        chk1("wrap_done_once", done, 1'b0);

        // BIN_DN aborted by halt at q=0
        do_cmd(OP_LOAD, MODE_BIN_UP, 4'h3, n);
        @(negedge clk);
        send(OP_RUN, MODE_BIN_DN, 4'hC);
        chk4("dn_q_3", q, 4'h3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk4("dn_q_0", q, 4'h0);
        chk4("dn_t_free", t_vec, 4'hF);
        halt = 1'b1;
        #1;
        chk4("halt_t_vec", t_vec, 4'h0);
        chk1("halt_busy", busy, 1'b1);
        @(negedge clk);
        halt = 1'b0;
        chk4("halt_q_hold", q, 4'h0);
        chk1("halt_idle", busy, 1'b0);
        chk1("halt_no_done", done, 1'b0);
        @(negedge clk);
        chk1("halt_no_done2", done, 1'b0);

        // GRAY_UP full walk to 1000
        do_cmd(OP_CLEAR, MODE_BIN_UP, 4'h0, n);
        @(negedge clk);
        send(OP_RUN, MODE_GRAY_UP, 4'b1000);
        for (int i = 0; i < 15; i++) begin
            chk4($sformatf("gray_q%0d", i), q, gray_seq[i]);
            chki($sformatf("gray_pop%0d", i), $countones(t_vec), 1);
            @(negedge clk);
        end
        chk4("gray_q_end", q, 4'b1000);
        chk1("gray_done", done, 1'b1);
        chk1("gray_busy", busy, 1'b0);
        @(negedge clk);

        // LOAD 1010 -> 0110
        do_cmd(OP_LOAD, MODE_BIN_UP, 4'hA, n);
        @(negedge clk);
        send(OP_LOAD, MODE_BIN_UP, 4'h6);
        chk4("load_t_vec", t_vec, 4'hC);
        chk1("load_busy", busy, 1'b1);
        @(negedge clk);
        chk4("load_q", q, 4'h6);
        chk1("load_done", done, 1'b1);
        chk4("load_t_after", t_vec, 4'h0);
        @(negedge clk);
        chk1("load_done_once", done, 1'b0);

        // LOAD equal, zero-length RUN, back-to-back
        send(OP_LOAD, MODE_BIN_UP, 4'h6);
        chk4("loadeq_t_vec", t_vec, 4'h0);
        @(negedge clk);
        chk1("loadeq_done", done, 1'b1);
        chk4("loadeq_q", q, 4'h6);
        @(negedge clk);
        send(OP_RUN, MODE_BIN_UP, 4'h6);
        chk1("zrun_busy", busy, 1'b0);
        chk1("zrun_done", done, 1'b1);
        chk1("zrun_ready", cmd_ready, 1'b1);
        send(OP_LOAD, MODE_BIN_UP, 4'h3);
        chk1("b2b_busy", busy, 1'b1);
        chk1("b2b_done_low", done, 1'b0);
        @(negedge clk);
        chk4("b2b_q", q, 4'h3);
        chk1("b2b_done", done, 1'b1);
        @(negedge clk);

        // Reset mid-RUN
        do_cmd(OP_CLEAR, MODE_BIN_UP, 4'h0, n);
        @(negedge clk);
        send(OP_RUN, MODE_BIN_UP, 4'h9);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk4("rst_run_q3", q, 4'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk4("rst_run_q", q, 4'h0);
        chk1("rst_run_busy", busy, 1'b0);
        chk1("rst_run_done", done, 1'b0);
        chk4("rst_run_t_vec", t_vec, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rst_run_ready", cmd_ready, 1'b1);
        chk1("rst_run_no_done", done, 1'b0);
        chk4("rst_run_q_hold", q, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
